// File: rtl/serial_adder_n_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

   // Number of slice iterations needed to cover a full operand.
   function automatic int sa_steps(input int width, input int slice);
      return width / slice;
   endfunction

endpackage

// File: rtl/serial_adder_n_if.sv
// Start/busy/done request bus of the serial adder: operands in, result and flags out.
interface serial_adder_n_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_adder_n_full_adder_slice.sv
// Combinational ripple of SLICE one-bit full adders; also exposes the carry into the top bit
// so the caller can form signed overflow on the final slice.
module full_adder_slice #(
   parameter int SLICE = 1
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   // Each stage owns its carry pair so the chain is a plain DAG of scalars.
   for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
      logic ci;
      logic co;
      if (gi == 0) begin : g_first
         assign ci = cin;
      end else begin : g_next
         assign ci = g_bit[gi-1].co;
      end
      assign s[gi] = a[gi] ^ b[gi] ^ ci;
      assign co    = (a[gi] & b[gi]) | (a[gi] & ci) | (b[gi] & ci);
   end

   assign cout  = g_bit[SLICE-1].co;
   assign c_msb = g_bit[SLICE-1].ci;

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one SLICE-wide full adder reused LSB-first over WIDTH/SLICE
// cycles, with a start/busy/done handshake and registered sum/cout/ovf results.
module serial_adder_n
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   serial_adder_n_if.slave bus
);

   localparam int             STEPS = sa_steps(WIDTH, SLICE);
   localparam int             CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0]  LAST  = CW'(STEPS - 1);

   if (WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("serial_adder_n: WIDTH must be >= 2 and a multiple of SLICE");
   end

   sa_state_t        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [SLICE-1:0] fa_a;
   logic [SLICE-1:0] fa_b;
   logic [SLICE-1:0] fa_s;
   logic             fa_cout;
   logic             fa_c_msb;

   always_comb begin
      fa_a = opa_q[int'(cnt_q) * SLICE +: SLICE];
      fa_b = opb_q[int'(cnt_q) * SLICE +: SLICE];
   end

   full_adder_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .a     (fa_a),
      .b     (fa_b),
      .cin   (carry_q),
      .s     (fa_s),
      .cout  (fa_cout),
      .c_msb (fa_c_msb)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               // Subtraction is a + ~b + 1: invert B here and seed the carry with sub.
               opa_d   = bus.a;
               opb_d   = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[int'(cnt_q) * SLICE +: SLICE] = fa_s;
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // On the last slice fa_c_msb is the carry into bit WIDTH-1.
               sum_d   = acc_d;
               cout_d  = fa_cout;
               ovf_d   = fa_c_msb ^ fa_cout;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed and table-driven checks of serial_adder_n for SLICE=1 and SLICE=4 (WIDTH=8),
// plus an exhaustive check of a one-bit full_adder_slice.
module tb_serial_adder_n;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   serial_adder_n_if #(.WIDTH(8)) if1 ();
   serial_adder_n_if #(.WIDTH(8)) if4 ();

   serial_adder_n #(.WIDTH(8), .SLICE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   serial_adder_n #(.WIDTH(8), .SLICE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

   logic [0:0] fa_a, fa_b, fa_s;
   logic       fa_cin, fa_cout, fa_cmsb;

   full_adder_slice #(.SLICE(1)) u_fa (
      .a(fa_a), .b(fa_b), .cin(fa_cin), .s(fa_s), .cout(fa_cout), .c_msb(fa_cmsb)
   );

   typedef struct {
      logic       sub;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t vecs [10];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                        input logic sb);
      if (sel) begin
         if4.start = st; if4.a = a; if4.b = b; if4.sub = sb;
      end else begin
         if1.start = st; if1.a = a; if1.b = b; if1.sub = sb;
      end
   endtask

   function automatic logic get_busy(input bit sel);
      return sel ? if4.busy : if1.busy;
   endfunction

   function automatic logic get_done(input bit sel);
      return sel ? if4.done : if1.done;
   endfunction

   // Reference arithmetic on plain integers: {ovf, cout, sum}.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic sb);
      int ua, ub, r, sa, sbs, sr;
      logic c, o;
      ua  = int'(a);
      ub  = int'(b);
      sa  = int'($signed(a));
      sbs = int'($signed(b));
      if (sb) begin
         r  = ua - ub;
         c  = (ua >= ub);
         sr = sa - sbs;
      end else begin
         r  = ua + ub;
         c  = (r > 255);
         sr = sa + sbs;
      end
      o = (sr > 127) || (sr < -128);
      return {o, c, 8'(r)};
   endfunction

   task automatic do_op(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic sb,
                        output logic [7:0] s, output logic co, output logic ov,
                        output int lat, output int busy_n);
      @(negedge clk);
      drive(sel, 1'b1, a, b, sb);
      @(posedge clk);
      @(negedge clk);
      drive(sel, 1'b0, 8'h00, 8'h00, 1'b0);
      lat    = 0;
      busy_n = 0;
      while (!get_done(sel) && lat < 40) begin
         if (get_busy(sel)) busy_n++;
         @(negedge clk);
         lat++;
      end
      if (lat >= 40) check("done_timeout", 32'(lat), 32'd0);
      s  = sel ? if4.sum  : if1.sum;
      co = sel ? if4.cout : if1.cout;
      ov = sel ? if4.ovf  : if1.ovf;
      $display("[TB] slice=%0d %s a=%02h b=%02h -> sum=%02h cout=%0d ovf=%0d lat=%0d",
               sel ? 4 : 1, sb ? "sub" : "add", a, b, s, co, ov, lat);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] s, ra, rb;
      logic       co, ov, rs;
      logic [7:0] held;
      int         lat, busy_n, bad, seen_done;
      logic [9:0] exp;

      vecs[0] = '{1'b0, 8'h3C, 8'h42, 8'h7E, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      vecs[7] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0};

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      fa_a = '0; fa_b = '0; fa_cin = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("reset_busy", 32'(get_busy(k[0])), 32'd0);
         check("reset_done", 32'(get_done(k[0])), 32'd0);
         check("reset_sum",  32'(k[0] ? if4.sum : if1.sum), 32'd0);
         check("reset_cout", 32'(k[0] ? if4.cout : if1.cout), 32'd0);
         check("reset_ovf",  32'(k[0] ? if4.ovf : if1.ovf), 32'd0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         fa_a = 1'(i >> 2); fa_b = 1'(i >> 1); fa_cin = 1'(i);
         #1;
         check("fa_s",    32'(fa_s),    32'(fa_a ^ fa_b ^ fa_cin));
         check("fa_cout", 32'(fa_cout), 32'((fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin)));
         check("fa_cmsb", 32'(fa_cmsb), 32'(fa_cin));
         $display("[TB] fa a=%0d b=%0d cin=%0d -> s=%0d cout=%0d", fa_a, fa_b, fa_cin, fa_s, fa_cout);
      end

      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < 2; k++) begin
            do_op(k[0], vecs[i].a, vecs[i].b, vecs[i].sub, s, co, ov, lat, busy_n);
            check("vec_sum",  32'(s),  32'(vecs[i].sum));
            check("vec_cout", 32'(co), 32'(vecs[i].cout));
            check("vec_ovf",  32'(ov), 32'(vecs[i].ovf));
            check("vec_latency", 32'(lat),    k[0] ? 32'd2 : 32'd8);
            check("vec_busy_cycles", 32'(busy_n), k[0] ? 32'd2 : 32'd8);
         end
      end

      // start held high, operands scrambled while the op is in flight.
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
      held = if1.sum;
      @(posedge clk);
      lat = 0; bad = 0;
      @(negedge clk);
      while (!if1.done && lat < 40) begin
         if (if1.sum !== held) bad++;
         drive(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
         @(negedge clk);
         lat++;
      end
      check("hs_latency", 32'(lat), 32'd8);
      check("hs_sum_stable_run", 32'(bad), 32'd0);
      check("hs_sum", 32'(if1.sum), 32'h46);
      $display("[TB] handshake op1 sum=%02h lat=%0d", if1.sum, lat);
      drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
      @(negedge clk);
      check("hs_idle_after_done_busy", 32'(if1.busy), 32'd0);
      check("hs_idle_after_done_done", 32'(if1.done), 32'd0);
      check("hs_idle_sum_held", 32'(if1.sum), 32'h46);
      @(negedge clk);
      check("hs_second_accept_busy", 32'(if1.busy), 32'd1);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      lat = 0; bad = 0;
      while (!if1.done && lat < 40) begin
         if (if1.sum !== 8'h46) bad++;
         @(negedge clk);
         lat++;
      end
      check("hs_sum_stable_run2", 32'(bad), 32'd0);
      check("hs_sum2", 32'(if1.sum), 32'h02);
      $display("[TB] handshake op2 sum=%02h", if1.sum);

      // Abort an add at step 3 with reset.
      do_op(1'b0, 8'h3C, 8'h42, 1'b0, s, co, ov, lat, busy_n);
      check("pre_abort_sum", 32'(s), 32'h7E);
      @(negedge clk);
      drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(if1.busy), 32'd0);
      check("abort_done", 32'(if1.done), 32'd0);
      check("abort_sum",  32'(if1.sum),  32'd0);
      check("abort_cout", 32'(if1.cout), 32'd0);
      check("abort_ovf",  32'(if1.ovf),  32'd0);
      rst_n = 1'b1;
      seen_done = 0;
      repeat (20) begin
         @(negedge clk);
         if (if1.done) seen_done++;
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      $display("[TB] reset mid-run sum=%02h done_pulses=%0d", if1.sum, seen_done);

      for (int i = 0; i < 240; i++) begin
         bit sel;
         sel = (i < 200);
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rs  = 1'($urandom);
         do_op(sel, ra, rb, rs, s, co, ov, lat, busy_n);
         exp = model(ra, rb, rs);
         check("sweep_result", 32'({ov, co, s}), 32'(exp));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
